edge_detect_multi: RTL and testbench
====================================

Name: edge_detect_multi

Overview:
- Parametrised, multi-channel successor to the single-bit transition-detecting Mealy FSM.
- Each of WIDTH channels tracks a debounced level with a 3-state FSM: INIT, LOW, HIGH.
- On an accepted transition it emits a registered one-cycle pulse, filtered by a global edge-select mode, and sets a sticky flag.
- Sits between synchronous status/strobe inputs and interrupt/event logic.

Parameters:
- WIDTH, 4, number of independent channels (>=1).
- DEBOUNCE, 2, consecutive cycles an opposite level must be sampled before a transition is accepted (>=1; 1 = accept on first differing sample).
- CNT_W, 8, width of each per-channel event counter (used only with the optional feature).

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- din  input  WIDTH  channel inputs, already synchronous to clk (no synchroniser inside).
- mode  input  2  edge select: 00 both edges, 01 rising only, 10 falling only, 11 pulses disabled.
- clr  input  1  synchronous clear of sticky flags (and counters if enabled).
- pulse  output  WIDTH  registered one-cycle event pulse per channel.
- sticky  output  WIDTH  per-channel latched event flag.
- level  output  WIDTH  debounced level per channel (0 in INIT and LOW, 1 in HIGH).
- valid  output  WIDTH  1 once the channel has left INIT.

Behaviour:
- Reset (rst=0, asynchronous):
  - all channels go to INIT with debounce count 0.
  - pulse, sticky, level and valid are all 0; counters are 0.
  - Reset wins over every other input, including mid-debounce.
- INIT: on the first clock after reset release, take din[i].
  - din[i]=0 -> LOW; din[i]=1 -> HIGH.
  - No pulse and no debounce on this step. valid[i] goes to 1 on that same edge.
- LOW:
  - din[i]=1: increment cnt; when cnt==DEBOUNCE-1 on an edge with din[i]=1, go to HIGH and clear cnt.
  - din[i]=0: cnt=0 (a glitch shorter than DEBOUNCE cycles is ignored).
- HIGH: mirror of LOW, with din[i]=0 driving the transition to LOW.
- Latency:
  - din[i] changes before edge N and holds.
  - The state and level change at edge N+DEBOUNCE-1.
  - pulse[i] is high for exactly the cycle following that edge.
- Pulse qualification, using mode sampled on the transition edge:
  - LOW->HIGH pulses if mode is 00 or 01.
  - HIGH->LOW pulses if mode is 00 or 10.
  - mode 11: the FSM and level still track, but there are no pulses.
  - A mode change takes effect on the next edge; it never alters the FSM state.
- sticky[i]:
  - Set on any edge where pulse[i] is generated.
  - Cleared on an edge with clr=1.
  - clr and a new pulse on the same edge -> sticky stays 1 (set wins).
- Channels are fully independent; simultaneous transitions on several channels each pulse in the same cycle.
- Debounce count width is clog2(DEBOUNCE)+1 bits; the count never exceeds DEBOUNCE-1.

Optional Feature:
- Macro EDGE_DETECT_CNT_EN.
- Defined:
  - Adds output evt_cnt (WIDTH*CNT_W, channel i at bits [i*CNT_W +: CNT_W]).
  - Each channel has a counter that increments on every generated pulse and saturates at 2^CNT_W-1 (no wrap).
  - clr sets it to 0; clr together with a pulse on the same edge -> 1.
  - Reset -> 0.
- Undefined: the evt_cnt port and counters are absent; CNT_W is ignored.

Test Plan:
- Reset/INIT:
  - Stimulus: hold rst=0 with din=4'b1010; release.
  - Response: after one edge level=4'b1010, valid=4'b1111, pulse=0, sticky=0.
- Debounce, WIDTH=4, DEBOUNCE=2, mode=00:
  - 1-cycle high glitch on din[0] from LOW -> no pulse, level[0]=0.
  - A 2-cycle high on din[0] -> level[0]=1 at the 2nd edge, pulse[0]=1 for exactly one cycle, sticky[0]=1.
- Mode filter, mode=01:
  - Toggle din[1] 0->1->0, each level held for 4 cycles.
  - Response: one pulse on the rise only, level[1] follows both transitions.
  - With mode=11 the same stimulus gives no pulses.
- clr interaction:
  - clr asserted on the same edge as a new pulse on ch2 -> sticky[2] stays 1.
  - clr alone on a later edge -> sticky[2]=0.
- Reset mid-debounce: drop rst during cnt=1 of a rising debounce -> all outputs 0 immediately (asynchronous); after release the channel re-enters via INIT with no pulse.
- EDGE_DETECT_CNT_EN, CNT_W=2:
  - 5 accepted edges on ch3 -> evt_cnt[3] reads 1,2,3,3,3 (saturates).
  - clr -> 0.

Source files
------------

// File: rtl/edge_detect_multi.sv
// Multi-channel debounced edge detector: per-channel INIT/LOW/HIGH FSM, mode-filtered pulses,
// sticky flags. Define EDGE_DETECT_CNT_EN to add saturating per-channel event counters (evt_cnt).
module edge_detect_multi #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned DEBOUNCE = 2,
  parameter int unsigned CNT_W    = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       din,
  input  logic [1:0]             mode,
  input  logic                   clr,
  output logic [WIDTH-1:0]       pulse,
  output logic [WIDTH-1:0]       sticky,
  output logic [WIDTH-1:0]       level,
  output logic [WIDTH-1:0]       valid
`ifdef EDGE_DETECT_CNT_EN
  ,
  output logic [WIDTH*CNT_W-1:0] evt_cnt
`endif
);

  localparam int unsigned    DbW    = $clog2(DEBOUNCE) + 1;
  localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE - 1);

  localparam logic [1:0] StInit = 2'd0;
  localparam logic [1:0] StLow  = 2'd1;
  localparam logic [1:0] StHigh = 2'd2;

  // mode[1] masks rising edges, mode[0] masks falling edges.
  logic rise_ok;
  logic fall_ok;
  assign rise_ok = ~mode[1];
  assign fall_ok = ~mode[0];

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    logic [1:0]     state_q, state_d;
    logic [DbW-1:0] cnt_q, cnt_d;
    logic           pulse_q, pulse_d;
    logic           sticky_q, sticky_d;

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pulse_d = 1'b0;
      case (state_q)
        StInit: begin
          state_d = din[i] ? StHigh : StLow;
          cnt_d   = '0;
        end
        StLow: begin
          if (din[i]) begin
            if (cnt_q == DbLast) begin
              state_d = StHigh;
              cnt_d   = '0;
              pulse_d = rise_ok;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            cnt_d = '0;
          end
        end
        StHigh: begin
          if (!din[i]) begin
            if (cnt_q == DbLast) begin
              state_d = StLow;
              cnt_d   = '0;
              pulse_d = fall_ok;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            cnt_d = '0;
          end
        end
        default: begin
          state_d = StInit;
          cnt_d   = '0;
        end
      endcase
      // A new event outranks a simultaneous clear.
      sticky_d = pulse_d | (sticky_q & ~clr);
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state_q  <= StInit;
        cnt_q    <= '0;
        pulse_q  <= 1'b0;
        sticky_q <= 1'b0;
      end else begin
        state_q  <= state_d;
        cnt_q    <= cnt_d;
        pulse_q  <= pulse_d;
        sticky_q <= sticky_d;
      end
    end

    assign pulse[i]  = pulse_q;
    assign sticky[i] = sticky_q;
    assign level[i]  = (state_q == StHigh);
    assign valid[i]  = (state_q != StInit);

`ifdef EDGE_DETECT_CNT_EN
    logic [CNT_W-1:0] evt_q, evt_d;

    always_comb begin
      evt_d = evt_q;
      if (clr) begin
        evt_d = CNT_W'(pulse_d);
      end else if (pulse_d && (evt_q != {CNT_W{1'b1}})) begin
        evt_d = evt_q + 1'b1;
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        evt_q <= '0;
      end else begin
        evt_q <= evt_d;
      end
    end

    assign evt_cnt[i*CNT_W +: CNT_W] = evt_q;
`endif
  end

`ifndef EDGE_DETECT_CNT_EN
  // CNT_W only shapes the counters, which are absent in this build.
  if (CNT_W == 0) begin : g_no_cnt
  end
`endif

endmodule

// File: tb/tb_edge_detect_multi.sv
// Self-checking bench for edge_detect_multi: directed scenarios plus randomized traffic,
// all compared against an event-level reference model.
module tb_edge_detect_multi;

  localparam int unsigned WIDTH    = 4;
  localparam int unsigned DEBOUNCE = 2;
  localparam int unsigned CNT_W    = 2;
  localparam int          CntMax   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic [1:0]       mode = 2'b00;
  logic             clr = 1'b0;
  logic [WIDTH-1:0] pulse, sticky, level, valid;
`ifdef EDGE_DETECT_CNT_EN
  logic [WIDTH*CNT_W-1:0] evt_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: debounced level plus a run length of consecutive differing samples.
  bit m_valid [WIDTH];
  bit m_level [WIDTH];
  bit m_pulse [WIDTH];
  bit m_sticky[WIDTH];
  int m_run   [WIDTH];
  int m_cnt   [WIDTH];

  edge_detect_multi #(
    .WIDTH    (WIDTH),
    .DEBOUNCE (DEBOUNCE),
    .CNT_W    (CNT_W)
  ) u_dut (
    .clk     (clk),
    .rst     (rst),
    .din     (din),
    .mode    (mode),
    .clr     (clr),
    .pulse   (pulse),
    .sticky  (sticky),
    .level   (level),
    .valid   (valid)
`ifdef EDGE_DETECT_CNT_EN
    ,
    .evt_cnt (evt_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < WIDTH; i++) begin
      m_valid[i]  = 1'b0;
      m_level[i]  = 1'b0;
      m_pulse[i]  = 1'b0;
      m_sticky[i] = 1'b0;
      m_run[i]    = 0;
      m_cnt[i]    = 0;
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < WIDTH; i++) begin
      bit ev;
      bit pass;
      ev = 1'b0;
      if (!m_valid[i]) begin
        m_valid[i] = 1'b1;
        m_level[i] = din[i];
        m_run[i]   = 0;
      end else if (din[i] != m_level[i]) begin
        m_run[i]++;
        if (m_run[i] == int'(DEBOUNCE)) begin
          m_level[i] = ~m_level[i];
          m_run[i]   = 0;
          ev         = 1'b1;
        end
      end else begin
        m_run[i] = 0;
      end
      pass = ev && (mode == 2'b00 || (m_level[i] ? mode == 2'b01 : mode == 2'b10));
      m_pulse[i]  = pass;
      m_sticky[i] = pass | (m_sticky[i] & ~clr);
      if (clr) m_cnt[i] = pass ? 1 : 0;
      else if (pass) m_cnt[i] = (m_cnt[i] >= CntMax) ? CntMax : m_cnt[i] + 1;
    end
  endtask

  function automatic logic [4*WIDTH-1:0] exp_vec();
    logic [4*WIDTH-1:0] v;
    for (int i = 0; i < WIDTH; i++) begin
      v[i]           = m_valid[i];
      v[WIDTH+i]     = m_level[i];
      v[2*WIDTH+i]   = m_sticky[i];
      v[3*WIDTH+i]   = m_pulse[i];
    end
    return v;
  endfunction

  function automatic logic [WIDTH*CNT_W-1:0] exp_cnt();
    logic [WIDTH*CNT_W-1:0] v;
    for (int i = 0; i < WIDTH; i++) v[i*CNT_W +: CNT_W] = CNT_W'(m_cnt[i]);
    return v;
  endfunction

  // Inputs are held across the edge, so the model sees what the DUT samples.
  task automatic step();
    if (!rst) model_reset();
    else model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; din = 4'b1010; mode = 2'b00; clr = 1'b0;
    model_reset();
    #23;
    checks++;
    if ({pulse, sticky, level, valid} !== '0) begin
      errors++;
      $display("FAIL reset_hold got=%h exp=0", {pulse, sticky, level, valid});
    end
    @(posedge clk); #1;
    rst = 1'b1;
    step();
    checks++;
    if ({pulse, sticky, level, valid} !== exp_vec()) begin
      errors++;
      $display("FAIL init_model got=%h exp=%h", {pulse, sticky, level, valid}, exp_vec());
    end
    checks++;
    if (level !== 4'b1010 || valid !== 4'hf || pulse !== 4'h0 || sticky !== 4'h0) begin
      errors++;
      $display("FAIL init_take level=%b valid=%b pulse=%b sticky=%b exp 1010/1111/0000/0000",
               level, valid, pulse, sticky);
    end
  endtask

  task automatic test_debounce();
    int np;
    mode = 2'b00; din = '0;
    repeat (4) begin
      step();
      checks++;
      if ({pulse, sticky, level, valid} !== exp_vec()) begin
        errors++;
        $display("FAIL settle got=%h exp=%h", {pulse, sticky, level, valid}, exp_vec());
      end
    end
    np = 0;
    for (int k = 0; k < 4; k++) begin
      din[0] = (k == 0);
      step();
      np += pulse[0];
      checks++;
      if ({pulse, sticky, level, valid} !== exp_vec()) begin
        errors++;
        $display("FAIL glitch got=%h exp=%h", {pulse, sticky, level, valid}, exp_vec());
      end
    end
    checks++;
    if (np != 0 || level[0] !== 1'b0) begin
      errors++;
      $display("FAIL glitch_ignored pulses=%0d level0=%b exp 0/0", np, level[0]);
    end
    din[0] = 1'b1;
    step();
    checks++;
    if (level[0] !== 1'b0 || pulse[0] !== 1'b0) begin
      errors++;
      $display("FAIL rise_first_edge level0=%b pulse0=%b exp 0/0", level[0], pulse[0]);
    end
    step();
    checks++;
    if (level[0] !== 1'b1 || pulse[0] !== 1'b1 || sticky[0] !== 1'b1) begin
      errors++;
      $display("FAIL rise_accept level0=%b pulse0=%b sticky0=%b exp 1/1/1",
               level[0], pulse[0], sticky[0]);
    end
    step();
    checks++;
    if (pulse[0] !== 1'b0 || level[0] !== 1'b1 || {pulse, sticky, level, valid} !== exp_vec()) begin
      errors++;
      $display("FAIL pulse_one_cycle got=%h exp=%h", {pulse, sticky, level, valid}, exp_vec());
    end
  endtask

  task automatic test_mode_filter();
    int np;
    for (int k = 0; k < 2; k++) begin
      mode = (k == 0) ? 2'b01 : 2'b11;
      np = 0;
      for (int ph = 0; ph < 2; ph++) begin
        din[1] = (ph == 0);
        repeat (4) begin
          step();
          np += pulse[1];
          checks++;
          if ({pulse, sticky, level, valid} !== exp_vec()) begin
            errors++;
            $display("FAIL mode_track mode=%b got=%h exp=%h", mode,
                     {pulse, sticky, level, valid}, exp_vec());
          end
        end
        checks++;
        if (level[1] !== din[1]) begin
          errors++;
          $display("FAIL mode_level mode=%b level1=%b exp=%b", mode, level[1], din[1]);
        end
      end
      checks++;
      if (np != ((k == 0) ? 1 : 0)) begin
        errors++;
        $display("FAIL mode_pulses mode=%b got=%0d exp=%0d", mode, np, (k == 0) ? 1 : 0);
      end
    end
    mode = 2'b00;
  endtask

  task automatic test_clr();
    mode = 2'b00;
    clr = 1'b1; step(); clr = 1'b0;
    din[2] = ~m_level[2];
    step();
    clr = 1'b1;
    step();
    checks++;
    if (pulse[2] !== 1'b1 || sticky[2] !== 1'b1 || {pulse, sticky, level, valid} !== exp_vec()) begin
      errors++;
      $display("FAIL clr_with_pulse pulse2=%b sticky2=%b exp 1/1", pulse[2], sticky[2]);
    end
    clr = 1'b0;
    step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    checks++;
    if (sticky[2] !== 1'b0 || {pulse, sticky, level, valid} !== exp_vec()) begin
      errors++;
      $display("FAIL clr_alone sticky2=%b exp 0", sticky[2]);
    end
  endtask

  task automatic test_reset_mid();
    mode = 2'b00; din[0] = 1'b0;
    repeat (3) step();
    din[0] = 1'b1;
    step();
    rst = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({pulse, sticky, level, valid} !== '0) begin
      errors++;
      $display("FAIL reset_async got=%h exp=0", {pulse, sticky, level, valid});
    end
    @(posedge clk); #1;
    rst = 1'b1;
    step();
    checks++;
    if (pulse !== 4'h0 || level[0] !== 1'b1 || valid !== 4'hf
        || {pulse, sticky, level, valid} !== exp_vec()) begin
      errors++;
      $display("FAIL reset_reinit got=%h exp=%h", {pulse, sticky, level, valid}, exp_vec());
    end
    step();
    checks++;
    if (pulse[0] !== 1'b0 || {pulse, sticky, level, valid} !== exp_vec()) begin
      errors++;
      $display("FAIL reset_no_pulse got=%h exp=%h", {pulse, sticky, level, valid}, exp_vec());
    end
  endtask

`ifdef EDGE_DETECT_CNT_EN
  task automatic test_counter();
    logic [CNT_W-1:0] c3;
    int seq[5] = '{1, 2, 3, 3, 3};
    mode = 2'b00;
    clr = 1'b1; step(); clr = 1'b0;
    for (int e = 0; e < 5; e++) begin
      din[3] = ~m_level[3];
      repeat (DEBOUNCE) step();
      c3 = evt_cnt[3*CNT_W +: CNT_W];
      checks++;
      if (int'(c3) != seq[e] || evt_cnt !== exp_cnt()) begin
        errors++;
        $display("FAIL cnt_sat edge=%0d got=%0d exp=%0d", e, c3, seq[e]);
      end
    end
    clr = 1'b1; step(); clr = 1'b0;
    checks++;
    if (evt_cnt !== '0) begin
      errors++;
      $display("FAIL cnt_clr got=%h exp=0", evt_cnt);
    end
  endtask
`endif

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < WIDTH; i++) if ($urandom_range(2) == 0) din[i] = ~din[i];
      if ($urandom_range(15) == 0) mode = 2'($urandom_range(3));
      clr = ($urandom_range(7) == 0);
      step();
      checks++;
      if ({pulse, sticky, level, valid} !== exp_vec()) begin
        errors++;
        $display("FAIL random n=%0d got=%h exp=%h", n, {pulse, sticky, level, valid}, exp_vec());
      end
`ifdef EDGE_DETECT_CNT_EN
      checks++;
      if (evt_cnt !== exp_cnt()) begin
        errors++;
        $display("FAIL random_cnt n=%0d got=%h exp=%h", n, evt_cnt, exp_cnt());
      end
`endif
    end
    clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_mode_filter();
    test_clr();
    test_reset_mid();
`ifdef EDGE_DETECT_CNT_EN
    test_counter();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
